// File: rtl/store_narrow_unit.sv
// Store narrowing unit: places SB/SH/SW register data onto a word-wide data RAM
// that has no byte enables. Sub-word stores use read-modify-write; word stores
// write directly.
// Optional feature macro: ALIGN_CHECK_EN (misaligned half/word requests are
// rejected through a one-cycle ERR state with no memory access).
module store_narrow_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StMerge,
    StWrite,
    StDone
`ifdef ALIGN_CHECK_EN
    ,
    StErr
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged;
  logic [1:0]        byte_lane;
  logic              half_lane;
  logic              accept;
  logic              misaligned;

  assign accept = (state_q == StIdle) && start;

`ifdef ALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // State register; async reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (misaligned) begin
`ifdef ALIGN_CHECK_EN
            state_d = StErr;
`else
            state_d = StIdle;
`endif
          end else if (size[1]) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = StMerge;
      StMerge: state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
`ifdef ALIGN_CHECK_EN
      StErr:   state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Request latch; the data register is reused to hold the merged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      size_q  <= size;
      lane_q  <= addr[1:0];
      addr_q  <= {addr[ADDR_W-1:2], 2'b00};
      wdata_q <= wdata_in;
    end else if (state_q == StMerge) begin
      wdata_q <= merged;
    end
  end

  assign byte_lane = BIG_ENDIAN ? (2'd3 - lane_q) : lane_q;
  assign half_lane = BIG_ENDIAN ? ~lane_q[1] : lane_q[1];

  // Lane replacement over the word just read from memory.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      unique case (byte_lane)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (half_lane) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Moore outputs straight from state so reset removes them immediately.
  always_comb begin
    busy   = (state_q != StIdle);
    mem_rd = (state_q == StRead);
    mem_wr = (state_q == StWrite);
    done   = (state_q == StDone);
    err    = 1'b0;
`ifdef ALIGN_CHECK_EN
    if (state_q == StErr) begin
      done = 1'b1;
      err  = 1'b1;
    end
`endif
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
